// File: rtl/partial_sum_unit.sv
// Purpose: one MSDAP u-group partial sum, sum of +/- x(n-k) into a 40-bit accumulator feeding the shift accumulator.
// Latency: 2 cycles per coefficient; acc_valid in cycle 2*rj_count+2 counting the start cycle as 0.
// Backpressure: coef_ready only in FETCH; stalls indefinitely without coef_valid; start ignored while busy.
module partial_sum_unit #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int ADDR_W = 8
) (
  input  logic              sclk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] rj_count,
  input  logic              init_sel,
  input  logic [ACC_W-1:0]  acc_init,
  input  logic              last_group,
  input  logic [DATA_W-1:0] n_index,
  input  logic [ADDR_W-1:0] newest_ptr,
  input  logic [ADDR_W:0]   coef,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_data,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              shift_en,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rj_q, rj_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   n_q, n_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                sign_q, sign_d;
  logic                zero_q, zero_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    acc_out_q, acc_out_d;
  logic                acc_valid_q, acc_valid_d;
  logic                shift_en_q, shift_en_d;
  logic [ADDR_W-1:0]   x_addr_q, x_addr_d;
  logic                busy_q, busy_d;

  logic [ADDR_W-1:0]   coef_k;
  logic [ACC_W-1:0]    term;

  assign coef_k = coef[ADDR_W-1:0];

  // Sample placed at bits [39:16] with sign extension; pre-history samples contribute nothing.
  always_comb begin
    term = '0;
    if (!zero_q) begin
      term = {{(ACC_W-2*DATA_W){x_data[DATA_W-1]}}, x_data, {DATA_W{1'b0}}};
    end
  end

  // Next-state and datapath control for the fetch/read/accumulate sequence.
  always_comb begin
    state_d     = state_q;
    rj_d        = rj_q;
    last_d      = last_q;
    n_d         = n_q;
    ptr_d       = ptr_q;
    sign_d      = sign_q;
    zero_d      = zero_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    acc_valid_d = 1'b0;
    shift_en_d  = 1'b0;
    x_addr_d    = x_addr_q;
    busy_d      = busy_q;
    coef_ready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A start coinciding with the acc_valid cycle waits one more idle cycle.
        if (start && !acc_valid_q) begin
          rj_d    = rj_count;
          last_d  = last_group;
          n_d     = n_index;
          ptr_d   = newest_ptr;
          cnt_d   = '0;
          acc_d   = init_sel ? acc_init : '0;
          busy_d  = 1'b1;
          state_d = (rj_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        coef_ready = 1'b1;
        if (coef_valid) begin
          sign_d   = coef[ADDR_W];
          x_addr_d = ptr_q - coef_k;
          zero_d   = {{(DATA_W-ADDR_W){1'b0}}, coef_k} > n_q;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        acc_d   = sign_q ? (acc_q - term) : (acc_q + term);
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == rj_q) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        acc_out_d   = acc_q;
        acc_valid_d = 1'b1;
        shift_en_d  = ~last_q;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any group in flight.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rj_q        <= '0;
      last_q      <= 1'b0;
      n_q         <= '0;
      ptr_q       <= '0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      shift_en_q  <= 1'b0;
      x_addr_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rj_q        <= rj_d;
      last_q      <= last_d;
      n_q         <= n_d;
      ptr_q       <= ptr_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
      shift_en_q  <= shift_en_d;
      x_addr_q    <= x_addr_d;
      busy_q      <= busy_d;
    end
  end

  assign x_addr    = x_addr_q;
  assign acc_out   = acc_out_q;
  assign acc_valid = acc_valid_q;
  assign shift_en  = shift_en_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_partial_sum_unit.sv
// Purpose: directed and randomized checks of partial_sum_unit against an arithmetic reference model.
// Latency: checks the 2*rj_count+2 start-to-acc_valid timing, extended by injected FETCH stalls.
// Backpressure: inserts coef_valid stalls, ignored start pulses and stray coef_valid during READ.
module tb_partial_sum_unit;

  logic        sclk;
  logic        reset_n;
  logic        start;
  logic [7:0]  rj_count;
  logic        init_sel;
  logic [39:0] acc_init;
  logic        last_group;
  logic [15:0] n_index;
  logic [7:0]  newest_ptr;
  logic [8:0]  coef;
  logic        coef_valid;
  logic        coef_ready;
  logic [7:0]  x_addr;
  logic [15:0] x_data;
  logic [39:0] acc_out;
  logic        acc_valid;
  logic        shift_en;
  logic        busy;

  logic [15:0] mem [0:255];
  assign x_data = mem[x_addr];

  partial_sum_unit dut (
    .sclk(sclk), .reset_n(reset_n), .start(start), .rj_count(rj_count),
    .init_sel(init_sel), .acc_init(acc_init), .last_group(last_group),
    .n_index(n_index), .newest_ptr(newest_ptr), .coef(coef),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .x_addr(x_addr),
    .x_data(x_data), .acc_out(acc_out), .acc_valid(acc_valid),
    .shift_en(shift_en), .busy(busy)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Group description shared by the stimulus steps and the model.
  logic        g_init;
  logic [39:0] g_acc;
  logic        g_last;
  logic [15:0] g_n;
  logic [7:0]  g_ptr;
  logic [8:0]  cq[$];
  int          stq[$];
  logic [39:0] got_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sum of signed samples scaled by 2^16, modulo 2^40.
  function automatic logic [39:0] model();
    longint s;
    longint t;
    int k;
    logic [7:0] a;
    s = g_init ? longint'({24'd0, g_acc}) : 64'sd0;
    for (int i = 0; i < cq.size(); i++) begin
      k = int'(cq[i][7:0]);
      a = g_ptr - cq[i][7:0];
      if (k > int'(g_n)) t = 0;
      else t = longint'($signed(mem[a])) * 65536;
      if (cq[i][8]) s = s - t;
      else s = s + t;
    end
    return s[39:0];
  endfunction

  task automatic run_group(input string tag);
    int s;
    int tot;
    int t;
    int rj;
    logic [39:0] e;
    logic [7:0]  ea;
    e = model();
    rj = cq.size();
    tot = 0;
    for (int i = 0; i < stq.size(); i++) tot += stq[i];
    @(negedge sclk);
    start = 1'b1; rj_count = 8'(rj); init_sel = g_init; acc_init = g_acc;
    last_group = g_last; n_index = g_n; newest_ptr = g_ptr;
    s = cyc;
    @(negedge sclk);
    start = 1'b0;
    chk({tag, " busy_set"}, 64'(busy), 64'(1));
    for (int i = 0; i < rj; i++) begin
      for (int j = 0; j < stq[i]; j++) begin
        chk({tag, " stall_rdy"}, 64'(coef_ready), 64'(1));
        start = 1'b1; rj_count = 8'd0;
        @(negedge sclk);
        start = 1'b0;
      end
      chk({tag, " rdy"}, 64'(coef_ready), 64'(1));
      coef_valid = 1'b1; coef = cq[i];
      @(negedge sclk);
      ea = g_ptr - cq[i][7:0];
      chk({tag, " x_addr"}, 64'(x_addr), 64'(ea));
      chk({tag, " rdy_low"}, 64'(coef_ready), 64'(0));
      coef_valid = (stq[i] != 0); coef = 9'h1FF;
      @(negedge sclk);
      coef_valid = 1'b0;
    end
    t = 0;
    while (!acc_valid && t < 12) begin
      @(negedge sclk);
      t++;
    end
    chk({tag, " acc_valid"}, 64'(acc_valid), 64'(1));
    chk({tag, " latency"}, 64'(cyc - s), 64'(2 * rj + 2 + tot));
    chk({tag, " acc_out"}, 64'(acc_out), 64'(e));
    chk({tag, " shift_en"}, 64'(shift_en), 64'(!g_last));
    got_acc = acc_out;
    @(negedge sclk);
    chk({tag, " pulse"}, 64'(acc_valid), 64'(0));
    chk({tag, " busy_clr"}, 64'(busy), 64'(0));
    chk({tag, " hold"}, 64'(acc_out), 64'(e));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; rj_count = '0; init_sel = 1'b0; acc_init = '0;
    last_group = 1'b0; n_index = '0; newest_ptr = '0; coef = '0; coef_valid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 7);

    // Reset state
    #12;
    chk("rst acc_out", 64'(acc_out), 64'(0));
    chk("rst acc_valid", 64'(acc_valid), 64'(0));
    chk("rst shift_en", 64'(shift_en), 64'(0));
    chk("rst coef_ready", 64'(coef_ready), 64'(0));
    chk("rst x_addr", 64'(x_addr), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    @(negedge sclk);
    reset_n = 1'b1;

    // Basic three-term group
    mem[8'h05] = 16'h0100; mem[8'h03] = 16'h0020; mem[8'h04] = 16'h0010;
    g_init = 0; g_acc = '0; g_last = 0; g_n = 16'd10; g_ptr = 8'h05;
    cq = '{9'h000, 9'h002, 9'h101}; stq = '{0, 0, 0};
    run_group("basic");
    chk("basic const", 64'(got_acc), 64'h00_0110_0000);

    // Negative sample sign extension
    mem[8'h40] = 16'h8000;
    g_n = 16'd10; g_ptr = 8'h40; cq = '{9'h000}; stq = '{0};
    run_group("neg");
    chk("neg const", 64'(got_acc), 64'hFF_8000_0000);

    // Feedback start value, final group
    mem[8'h10] = 16'h0001;
    g_init = 1; g_acc = 40'h00_0100_0000; g_last = 1; g_ptr = 8'h10;
    cq = '{9'h100}; stq = '{0};
    run_group("fb");
    chk("fb const", 64'(got_acc), 64'h00_00FF_0000);

    // Zero history: k=5 beyond n=2 contributes nothing
    mem[8'h1B] = 16'h7FFF; mem[8'h1E] = 16'h0003;
    g_init = 0; g_acc = '0; g_last = 0; g_n = 16'd2; g_ptr = 8'h20;
    cq = '{9'h005, 9'h002}; stq = '{0, 0};
    run_group("zhist");
    chk("zhist const", 64'(got_acc), 64'h00_0003_0000);

    // Empty group returns acc_init
    g_init = 1; g_acc = 40'h12_3456_789A; cq = {}; stq = {};
    run_group("empty");
    chk("empty const", 64'(got_acc), 64'h12_3456_789A);

    // Stall in FETCH with ignored start pulses
    mem[8'h80] = 16'h0200; mem[8'h7F] = 16'hFFFF;
    g_init = 0; g_n = 16'd100; g_ptr = 8'h80;
    cq = '{9'h000, 9'h101}; stq = '{4, 0};
    run_group("stall");
    chk("stall const", 64'(got_acc), 64'h00_0201_0000);

    // Randomized groups, including pointer wrap and pre-history terms
    for (int g = 0; g < 25; g++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      g_init = 1'($urandom); g_acc = {8'($urandom), 32'($urandom)};
      g_last = 1'($urandom); g_n = 16'($urandom_range(0, 24));
      g_ptr = 8'($urandom); cq = {}; stq = {};
      for (int i = 0; i < int'($urandom_range(0, 8)); i++) begin
        cq.push_back({1'($urandom), 8'($urandom_range(0, 31))});
        stq.push_back(int'($urandom_range(0, 2)));
      end
      run_group("rand");
    end

    // Reset mid-group after the first add
    g_init = 0; g_n = 16'd50; g_ptr = 8'h33;
    @(negedge sclk);
    start = 1'b1; rj_count = 8'd3; init_sel = 1'b0; n_index = g_n; newest_ptr = g_ptr;
    @(negedge sclk);
    start = 1'b0; coef_valid = 1'b1; coef = 9'h001;
    @(negedge sclk);
    coef_valid = 1'b0;
    @(negedge sclk);
    reset_n = 1'b0;
    #1;
    chk("midrst acc_out", 64'(acc_out), 64'(0));
    chk("midrst acc_valid", 64'(acc_valid), 64'(0));
    chk("midrst shift_en", 64'(shift_en), 64'(0));
    chk("midrst coef_ready", 64'(coef_ready), 64'(0));
    chk("midrst x_addr", 64'(x_addr), 64'(0));
    chk("midrst busy", 64'(busy), 64'(0));
    @(negedge sclk);
    reset_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge sclk);
        if (acc_valid || coef_ready) seen++;
      end
      chk("midrst idle", 64'(seen), 64'(0));
    end

    // Unit still works after the abort
    mem[8'h33] = 16'h0004;
    cq = '{9'h000}; stq = '{0}; g_last = 0; g_acc = '0;
    run_group("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/partial_sum_unit.md
Name: partial_sum_unit

Overview:
- Upstream neighbour of the MSDAP shift accumulator. For one u-group it reads rj_count coefficients from a coefficient stream. Each coefficient selects a past input sample x(n-k) and a sign.
- The selected samples are added or subtracted into a 40-bit accumulator. The accumulator starts either from zero or from the shift accumulator's fed-back output.
- The finished sum goes to the shift accumulator's in_bk input, with a one-cycle load strobe and a shift-enable flag.

Parameters:
- DATA_W, 16, input sample width (two's complement).
- ACC_W, 40, accumulator and output width.
- ADDR_W, 8, data-memory address width; the sample ring has 256 entries.

Ports:
- sclk  input  1  system clock; all state updates on posedge sclk.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a u-group; sampled only in IDLE.
- rj_count  input  8  number of coefficients in this group (0..255); latched on start.
- init_sel  input  1  latched on start; 0 = accumulator starts at 0, 1 = starts at acc_init.
- acc_init  input  40  feedback from shift accumulator out_bk; latched on start.
- last_group  input  1  latched on start; 1 = u=1 group (final group).
- n_index  input  16  index of the newest sample, n; latched on start.
- newest_ptr  input  8  ring address of x(n); latched on start.
- coef  input  9  bit 8 = sign (1 = subtract); bits 7:0 = delay k.
- coef_valid  input  1  coef holds a valid coefficient.
- coef_ready  output  1  block accepts a coefficient this cycle.
- x_addr  output  8  data-memory read address.
- x_data  input  16  sample at x_addr; asynchronous-read memory, valid in the same cycle.
- acc_out  output  40  finished sum; drives shift accumulator in_bk.
- acc_valid  output  1  one-cycle pulse, acc_out valid; drives shift accumulator load.
- shift_en  output  1  valid with acc_valid; equals NOT last_group.
- busy  output  1  high from start accepted until the DONE cycle completes.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE, accumulator = 0, acc_out = 0, acc_valid = 0, shift_en = 0, coef_ready = 0, x_addr = 0, busy = 0, term counter = 0.
- Reset mid-group aborts the group; no acc_valid is produced.

State machine: IDLE -> FETCH -> READ -> (FETCH or DONE) -> IDLE.
- IDLE:
  - On start: latch rj_count, init_sel, acc_init, last_group, n_index, newest_ptr.
  - Accumulator is loaded with init_sel ? acc_init : 0. Set busy = 1.
  - If rj_count = 0, go to DONE; otherwise go to FETCH.
- FETCH:
  - coef_ready = 1.
  - On coef_valid: latch sign and k, set x_addr = newest_ptr - k (mod 256).
  - Set zero_term = (k > n_index), so samples before time 0 read as zero. Go to READ.
  - Without coef_valid, stay in FETCH indefinitely.
- READ:
  - coef_ready = 0.
  - term = zero_term ? 0 : {8 copies of x_data[15], x_data, 16'b0}.
  - Accumulator = accumulator +/- term (minus when sign = 1).
  - Increment term counter. If counter reaches rj_count, go to DONE; otherwise go to FETCH.
- DONE:
  - acc_out <= accumulator, acc_valid = 1 for exactly one cycle, shift_en = ~last_group, busy = 0 next cycle.
  - Go to IDLE; acc_out holds its value until the next DONE.
- Throughput: 2 cycles per coefficient. Latency from start to acc_valid is 2*rj_count + 2 cycles (start-cycle edge counted as cycle 0).
- Arithmetic: 40-bit two's complement, wraps modulo 2^40, no saturation. k = 0 addresses x(n) itself.
- start asserted while busy is ignored. coef_valid outside FETCH is ignored; no coefficient is consumed.
- acc_valid and start in the same cycle: the new start is accepted only on the following IDLE cycle.

Test Plan:
- Reset mid-group: rj_count = 3, assert reset_n = 0 after the 1st add -> all outputs 0, state IDLE, no acc_valid pulse.
- rj_count = 3, init_sel = 0, n_index = 10, newest_ptr = 0x05, coefs {+k=0, +k=2, -k=1}, x(n) = 0x0100, x(n-2) = 0x0020, x(n-1) = 0x0010:
  - x_addr sequence is 0x05, 0x03, 0x04.
  - acc_out = 0x0000_0110_0000; acc_valid pulses at cycle 8; shift_en = 1.
- Negative sample: rj_count = 1, coef = +k=0, x = 0x8000 -> acc_out = 0xFF_8000_0000 (sign-extended).
- Feedback and final group: init_sel = 1, acc_init = 0x00_0100_0000, last_group = 1, coef = -k=0, x = 0x0001 -> acc_out = 0x00_00FF_0000, shift_en = 0.
- Zero-history terms:
  - n_index = 2, coef k = 5 -> term contributes 0 regardless of x_data.
  - rj_count = 0, init_sel = 1 -> acc_out = acc_init, acc_valid two cycles after start.
- Stall and ignored start: hold coef_valid low 4 cycles in FETCH and pulse start while busy -> accumulator unchanged, coef_ready stays high, second start ignored, final sum correct.
